// File: rtl/moore_10x0_seq_det_over.sv
// Moore overlapping sequence detector for the serial pattern 1,0,X,0
// (X = don't care, so both 1010 and 1000 match).
//
// Ports:
//   Clk - system clock, all state updates on the rising edge
//   Rst - synchronous reset, active-high; forces the state to S0
//   In  - serial data bit, sampled on the rising edge of Clk
//   OP  - detect flag, decoded from the current state only
//   CS  - current state register value (debug/monitor)
//   NS  - next state, combinational from CS and In (debug/monitor)
module moore_10x0_seq_det_over (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       In,
  output logic       OP,
  output logic [2:0] CS,
  output logic [2:0] NS
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // no progress
    S1 = 3'b001,  // seen "1"
    S2 = 3'b010,  // seen "10"
    S3 = 3'b011,  // seen "101"
    S4 = 3'b100,  // seen "100"
    S5 = 3'b101,  // matched "1010", trailing "10" kept for overlap
    S6 = 3'b110   // matched "1000", nothing kept
  } state_t;

  state_t state_q;
  state_t state_d;

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused code 111 falls back to S0
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = In ? S1 : S0;
      S1:      state_d = In ? S1 : S2;
      S2:      state_d = In ? S3 : S4;
      S3:      state_d = In ? S1 : S5;
      S4:      state_d = In ? S1 : S6;
      S5:      state_d = In ? S3 : S4;
      S6:      state_d = In ? S1 : S0;
      default: state_d = S0;
    endcase
  end

  // Output decode (Moore: current state only)
  always_comb begin
    OP = 1'b0;
    case (state_q)
      S5, S6:  OP = 1'b1;
      default: OP = 1'b0;
    endcase
  end

  assign CS = state_q;
  assign NS = state_d;

endmodule

// File: tb/tb_moore_10x0_seq_det_over.sv
// Self-checking bench for moore_10x0_seq_det_over. The reference model keeps
// the last few bits seen since reset and derives the expected state from the
// longest useful suffix of that history, and the detect flag from whether the
// last four bits read 1,0,X,0.
module tb_moore_10x0_seq_det_over;

  logic       Clk;
  logic       Rst;
  logic       In;
  logic       OP;
  logic [2:0] CS;
  logic [2:0] NS;

  int total = 0;
  int bad   = 0;

  // model: newest bit in hist[0], cnt = bits since reset (saturating at 4)
  logic [3:0] hist;
  int         cnt;
  bit         known;

  moore_10x0_seq_det_over dut (
    .Clk(Clk),
    .Rst(Rst),
    .In (In),
    .OP (OP),
    .CS (CS),
    .NS (NS)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Expected state code from the bit history since reset.
  function automatic logic [2:0] exp_state(input logic [3:0] h, input int n);
    if (n >= 4 && h[3] && !h[2] && !h[0]) return h[1] ? 3'b101 : 3'b110;
    if (n >= 3 && h[2:0] == 3'b101) return 3'b011;
    if (n >= 3 && h[2:0] == 3'b100) return 3'b100;
    if (n >= 2 && h[1:0] == 2'b10)  return 3'b010;
    if (n >= 1 && h[0])             return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic exp_detect(input logic [3:0] h, input int n);
    return (n >= 4) && h[3] && !h[2] && !h[0];
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  // One clock: drive on the falling edge, check NS before the rising edge,
  // then check CS/OP shortly after it.
  task automatic step(input logic r, input logic i);
    logic [3:0] nh;
    int         nn;
    @(negedge Clk);
    Rst = r;
    In  = i;
    #1;
    nh = {hist[2:0], i};
    nn = (cnt < 4) ? cnt + 1 : 4;
    if (known) chk("ns", NS, exp_state(nh, nn));
    @(posedge Clk);
    if (r) begin
      hist  = '0;
      cnt   = 0;
      known = 1'b1;
    end else begin
      hist = nh;
      cnt  = nn;
    end
    #1;
    if (known) begin
      chk("cs", CS, exp_state(hist, cnt));
      chk("op", {2'b00, OP}, {2'b00, exp_detect(hist, cnt)});
    end
  endtask

  task automatic seq(input logic [7:0] bits, input int len);
    for (int k = len - 1; k >= 0; k--) step(1'b0, bits[k]);
  endtask

  initial begin
    Rst   = 1'b1;
    In    = 1'b0;
    hist  = '0;
    cnt   = 0;
    known = 1'b0;

    // reset with In toggling
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("reset_cs", CS, 3'b000);
    chk("reset_ns_in1", NS, 3'b001);

    // basic 1010 match, directed constants
    seq(8'b0000_1010, 4);
    chk("m1010_cs", CS, 3'b101);
    chk("m1010_op", {2'b00, OP}, 3'b001);

    // 1000 match then drop to idle
    step(1'b1, 1'b0);
    seq(8'b0000_1000, 4);
    chk("m1000_cs", CS, 3'b110);
    step(1'b0, 1'b0);
    chk("after1000_cs", CS, 3'b000);
    chk("after1000_op", {2'b00, OP}, 3'b000);

    // overlap 101010 and 101000
    step(1'b1, 1'b0);
    seq(8'b0010_1010, 6);
    chk("ovl_a_cs", CS, 3'b101);
    step(1'b1, 1'b0);
    seq(8'b0010_1000, 6);
    chk("ovl_b_cs", CS, 3'b110);

    // non-match and recovery
    step(1'b1, 1'b0);
    seq(8'b0001_1011, 5);
    chk("nomatch_cs", CS, 3'b001);
    chk("nomatch_op", {2'b00, OP}, 3'b000);
    step(1'b1, 1'b0);
    seq(8'b0100_1010, 7);
    chk("recover_cs", CS, 3'b101);

    // reset mid-sequence
    step(1'b1, 1'b0);
    seq(8'b0000_0101, 3);
    chk("mid_cs", CS, 3'b011);
    step(1'b1, 1'b0);
    chk("midrst_cs", CS, 3'b000);
    chk("midrst_op", {2'b00, OP}, 3'b000);
    step(1'b0, 1'b0);
    chk("midrel_op", {2'b00, OP}, 3'b000);

    // random stream with occasional resets
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
